led_tick_sequencer: RTL and testbench

LED_TICK_SEQUENCER -- requirements
Module: led_tick_sequencer

---
 rtl/led_seq_pkg.sv | 44 ++++
 rtl/led_seq_prescaler.sv | 38 +++
 rtl/led_tick_sequencer.sv | 126 ++++++++++++
 tb/tb_led_tick_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED tick sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_seq_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

    localparam logic [LED_W-1:0] SEED_COUNT  = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] SEED_WALK   = LED_LSB;
    localparam logic [LED_W-1:0] SEED_BOUNCE = LED_LSB;
    localparam logic [LED_W-1:0] SEED_BLINK  = {LED_W{1'b1}};

    function automatic logic [LED_W-1:0] mode_seed(input mode_t m);
        logic [LED_W-1:0] s;
        unique case (m)
            MODE_COUNT:  s = SEED_COUNT;
            MODE_WALK:   s = SEED_WALK;
            MODE_BOUNCE: s = SEED_BOUNCE;
            MODE_BLINK:  s = SEED_BLINK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Rising-edge detector on tick_in plus a modulo-TICKS_PER_STEP rise counter.
// Latency: step is combinational in the cycle the rise is seen.
// Backpressure: none; clr holds the count at zero.
module led_seq_prescaler #(
    parameter int unsigned TICKS_PER_STEP = 4
) (
    input  logic bufr_clk,
    input  logic rst,
    input  logic tick_in,
    input  logic clr,
    output logic step
);

    localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_STEP - 1);

    logic        tick_d;
    logic        rise;
    logic [15:0] presc;

    // tick_in already lives in bufr_clk, so one flop is enough for edge detection
    assign rise = tick_in & ~tick_d;
    assign step = rise & ~clr & ~rst & (presc == PRESC_LAST);

    always_ff @(posedge bufr_clk) begin
        if (rst) begin
            tick_d <= 1'b0;
            presc  <= 16'd0;
        end else begin
            tick_d <= tick_in;
            if (clr) begin
                presc <= 16'd0;
            end else if (rise) begin
                presc <= (presc == PRESC_LAST) ? 16'd0 : presc + 16'd1;
            end
        end
    end

endmodule

// File: rtl/led_tick_sequencer.sv
// Steps a 4-bit LED pattern (count/walk/bounce/blink) every TICKS_PER_STEP tick rises.
// Latency: led/step_count/wrap update one edge after the qualifying rise.
// Backpressure: none; en gates running, dropping it blanks the LEDs.
module led_tick_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 4
) (
    input  logic             bufr_clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic [15:0]      step_count,
    output logic             wrap
);

    state_t           state_q, state_d;
    mode_t            active_mode, active_mode_d;
    mode_t            mode_sel;
    dir_t             dir, dir_d;
    logic [LED_W-1:0] led_d;
    logic [15:0]      step_count_d;
    logic             wrap_d;
    logic             step;

    assign mode_sel = mode_t'(mode);

    led_seq_prescaler #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_prescaler (
        .bufr_clk(bufr_clk),
        .rst     (rst),
        .tick_in (tick_in),
        .clr     (state_q == IDLE),
        .step    (step)
    );

    always_comb begin
        state_d       = state_q;
        active_mode_d = active_mode;
        dir_d         = dir;
        led_d         = led;
        step_count_d  = step_count;
        wrap_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                led_d = '0;
                if (en) begin
                    state_d       = RUN;
                    active_mode_d = mode_sel;
                    led_d         = mode_seed(mode_sel);
                    dir_d         = DIR_UP;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else if (step) begin
                    step_count_d = step_count + 16'd1;
                    if (mode_sel != active_mode) begin
                        // a new mode takes effect on a step boundary, restarting from its seed
                        active_mode_d = mode_sel;
                        led_d         = mode_seed(mode_sel);
                        dir_d         = DIR_UP;
                    end else begin
                        unique case (active_mode)
                            MODE_COUNT: begin
                                led_d  = led + LED_LSB;
                                wrap_d = (led == SEED_BLINK);
                            end
                            MODE_WALK: begin
                                led_d  = {led[LED_W-2:0], led[LED_W-1]};
                                wrap_d = (led == LED_MSB);
                            end
                            MODE_BOUNCE: begin
                                if (dir == DIR_UP) begin
                                    if (led == LED_MSB) begin
                                        led_d = led >> 1;
                                        dir_d = DIR_DOWN;
                                    end else begin
                                        led_d = led << 1;
                                    end
                                end else begin
                                    if (led == LED_LSB) begin
                                        led_d = led << 1;
                                        dir_d = DIR_UP;
                                    end else begin
                                        led_d  = led >> 1;
                                        wrap_d = (led_d == LED_LSB);
                                    end
                                end
                            end
                            MODE_BLINK: begin
                                led_d  = ~led;
                                wrap_d = (led == SEED_BLINK);
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge bufr_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            active_mode <= MODE_COUNT;
            dir         <= DIR_UP;
            led         <= '0;
            step_count  <= 16'd0;
            wrap        <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_mode <= active_mode_d;
            dir         <= dir_d;
            led         <= led_d;
            step_count  <= step_count_d;
            wrap        <= wrap_d;
        end
    end

endmodule

// File: tb/tb_led_tick_sequencer.sv
// Bench for led_tick_sequencer: two instances (4 and 1 ticks per step) against a sequence-table model.
// Directed tables for the pattern corner cases, then randomized en/mode/tick/rst traffic.
module tb_led_tick_sequencer;

    localparam int TPS_A = 4;
    localparam int TPS_B = 1;

    typedef struct {
        logic [3:0] led;
        logic       wrap;
    } vec_t;

    logic       bufr_clk;
    logic       rst;
    logic       tick_in;
    logic       en;
    logic [1:0] mode;
    logic [3:0] led_a, led_b;
    logic [15:0] step_count_a, step_count_b;
    logic       wrap_a, wrap_b;
    logic       preload_b;

    int n_checks;
    int n_errors;
    int wrap_seen_a;
    int wrap_seen_b;

    led_tick_sequencer #(.TICKS_PER_STEP(TPS_A)) dut_a (
        .bufr_clk  (bufr_clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .en        (en),
        .mode      (mode),
        .led       (led_a),
        .step_count(step_count_a),
        .wrap      (wrap_a)
    );

    led_tick_sequencer #(.TICKS_PER_STEP(TPS_B)) dut_b (
        .bufr_clk  (bufr_clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .en        (en),
        .mode      (mode),
        .led       (led_b),
        .step_count(step_count_b),
        .wrap      (wrap_b)
    );

    initial bufr_clk = 1'b0;
    always #5 bufr_clk = ~bufr_clk;

    // Reference model: each pattern is a list of LED values walked by index.
    function automatic logic [3:0] pat(input int md, input int idx);
        logic [3:0] p;
        case (md)
            0: p = 4'(idx);
            1: p = 4'(1 << idx);
            2: case (idx)
                   0: p = 4'h1;
                   1: p = 4'h2;
                   2: p = 4'h4;
                   3: p = 4'h8;
                   4: p = 4'h4;
                   default: p = 4'h2;
               endcase
            default: p = (idx == 0) ? 4'hF : 4'h0;
        endcase
        return p;
    endfunction

    function automatic int plen(input int md);
        case (md)
            0: return 16;
            1: return 4;
            2: return 6;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] wrap_led(input int md);
        return (md == 1 || md == 2) ? 4'h1 : 4'h0;
    endfunction

    logic        m_run[2];
    logic [3:0]  m_led[2];
    logic [15:0] m_cnt[2];
    logic        m_wrap[2];
    logic        m_tickd[2];
    int          m_rises[2];
    int          m_mode[2];
    int          m_idx[2];

    always @(posedge bufr_clk) begin
        for (int k = 0; k < 2; k++) begin
            logic r;
            int   tps;
            tps = (k == 0) ? TPS_A : TPS_B;
            m_wrap[k] = 1'b0;
            if (rst) begin
                m_run[k] = 1'b0; m_led[k] = 4'h0; m_cnt[k] = 16'h0;
                m_tickd[k] = 1'b0; m_rises[k] = 0; m_mode[k] = 0; m_idx[k] = 0;
            end else begin
                r = tick_in && !m_tickd[k];
                m_tickd[k] = tick_in;
                if (k == 1 && preload_b) m_cnt[k] = 16'hFFFF;
                if (!m_run[k]) begin
                    m_rises[k] = 0;
                    m_led[k] = 4'h0;
                    if (en) begin
                        m_run[k] = 1'b1; m_mode[k] = int'(mode); m_idx[k] = 0;
                        m_led[k] = pat(int'(mode), 0);
                    end
                end else if (!en) begin
                    m_run[k] = 1'b0; m_led[k] = 4'h0; m_rises[k] = 0;
                end else if (r) begin
                    m_rises[k]++;
                    if (m_rises[k] == tps) begin
                        m_rises[k] = 0;
                        m_cnt[k] = m_cnt[k] + 16'd1;
                        if (int'(mode) != m_mode[k]) begin
                            m_mode[k] = int'(mode); m_idx[k] = 0;
                            m_led[k] = pat(m_mode[k], 0);
                        end else begin
                            m_idx[k] = (m_idx[k] + 1) % plen(m_mode[k]);
                            m_led[k] = pat(m_mode[k], m_idx[k]);
                            m_wrap[k] = (m_led[k] == wrap_led(m_mode[k]));
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle and compare both instances with the model.
    task automatic cyc();
        @(negedge bufr_clk);
        chk("model_a_led",  {12'h0, led_a},  {12'h0, m_led[0]});
        chk("model_a_cnt",  step_count_a,    m_cnt[0]);
        chk("model_a_wrap", {15'h0, wrap_a}, {15'h0, m_wrap[0]});
        chk("model_b_led",  {12'h0, led_b},  {12'h0, m_led[1]});
        chk("model_b_cnt",  step_count_b,    m_cnt[1]);
        chk("model_b_wrap", {15'h0, wrap_b}, {15'h0, m_wrap[1]});
        if (wrap_a) wrap_seen_a++;
        if (wrap_b) wrap_seen_b++;
    endtask

    task automatic tick_wave(input int hi, input int lo);
        tick_in = 1'b1;
        repeat (hi) cyc();
        tick_in = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; tick_in = 1'b0; mode = 2'd0; preload_b = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    vec_t bounce_tab[6];

    initial begin
        logic [3:0] exp_led;
        n_checks = 0; n_errors = 0; wrap_seen_a = 0; wrap_seen_b = 0;
        rst = 1'b1; en = 1'b0; tick_in = 1'b0; mode = 2'd0; preload_b = 1'b0;

        bounce_tab[0] = '{4'b0010, 1'b0};
        bounce_tab[1] = '{4'b0100, 1'b0};
        bounce_tab[2] = '{4'b1000, 1'b0};
        bounce_tab[3] = '{4'b0100, 1'b0};
        bounce_tab[4] = '{4'b0010, 1'b0};
        bounce_tab[5] = '{4'b0001, 1'b1};

        // Reset state, and ticks while disabled take no steps
        do_reset();
        chk("rst_led_a", {12'h0, led_a}, 16'h0);
        chk("rst_cnt_a", step_count_a, 16'h0);
        chk("rst_wrap_a", {15'h0, wrap_a}, 16'h0);
        chk("rst_led_b", {12'h0, led_b}, 16'h0);
        chk("rst_cnt_b", step_count_b, 16'h0);
        tick_wave(1, 1); tick_wave(1, 1);
        chk("idle_cnt_b", step_count_b, 16'h0);

        // COUNT, 4 ticks per step, tick period 8 clocks
        en = 1'b1; mode = 2'd0; cyc();
        chk("count_seed", {12'h0, led_a}, 16'h0);
        wrap_seen_a = 0;
        for (int s = 1; s <= 16; s++) begin
            repeat (3) tick_wave(4, 4);
            exp_led = 4'(s - 1);
            chk("count_hold", {12'h0, led_a}, {12'h0, exp_led});
            tick_in = 1'b1; cyc();
            exp_led = 4'(s);
            chk("count_step_led", {12'h0, led_a}, {12'h0, exp_led});
            chk("count_step_cnt", step_count_a, 16'(s));
            chk("count_wrap", {15'h0, wrap_a}, (s == 16) ? 16'h1 : 16'h0);
            repeat (3) cyc();
            tick_in = 1'b0;
            repeat (4) cyc();
        end
        chk("count_wrap_pulses", 16'(wrap_seen_a), 16'h1);

        // BOUNCE, one tick per step
        do_reset();
        en = 1'b1; mode = 2'd2; cyc();
        chk("bounce_seed", {12'h0, led_b}, 16'h1);
        for (int i = 0; i < 6; i++) begin
            tick_in = 1'b1; cyc();
            chk("bounce_led", {12'h0, led_b}, {12'h0, bounce_tab[i].led});
            chk("bounce_wrap", {15'h0, wrap_b}, {15'h0, bounce_tab[i].wrap});
            tick_in = 1'b0; cyc();
            chk("bounce_wrap_off", {15'h0, wrap_b}, 16'h0);
        end

        // WALK -> BLINK change at 0100
        do_reset();
        en = 1'b1; mode = 2'd1; cyc();
        tick_wave(1, 1); tick_wave(1, 1);
        chk("walk_at_0100", {12'h0, led_b}, 16'h4);
        mode = 2'd3; cyc(); cyc();
        chk("mode_chg_no_effect", {12'h0, led_b}, 16'h4);
        tick_in = 1'b1; cyc();
        chk("blink_seed_led", {12'h0, led_b}, 16'hF);
        chk("blink_seed_wrap", {15'h0, wrap_b}, 16'h0);
        chk("blink_seed_cnt", step_count_b, 16'd3);
        tick_in = 1'b0; cyc();
        tick_in = 1'b1; cyc();
        chk("blink_off_led", {12'h0, led_b}, 16'h0);
        chk("blink_off_wrap", {15'h0, wrap_b}, 16'h1);
        chk("blink_off_cnt", step_count_b, 16'd4);
        tick_in = 1'b0; cyc();

        // en dropped at 1000, reasserted
        do_reset();
        en = 1'b1; mode = 2'd1; cyc();
        repeat (3) tick_wave(1, 1);
        chk("walk_at_1000", {12'h0, led_b}, 16'h8);
        en = 1'b0; cyc();
        chk("idle_led", {12'h0, led_b}, 16'h0);
        tick_wave(1, 1);
        chk("idle_cnt_held", step_count_b, 16'd3);
        en = 1'b1; cyc();
        chk("rerun_seed", {12'h0, led_b}, 16'h1);
        chk("rerun_cnt", step_count_b, 16'd3);
        tick_wave(1, 1);
        chk("rerun_step_cnt", step_count_b, 16'd4);

        // rst coincident with a rise at step_count 5
        do_reset();
        en = 1'b1; mode = 2'd1; cyc();
        repeat (5) tick_wave(1, 1);
        chk("pre_rst_cnt", step_count_b, 16'd5);
        rst = 1'b1; tick_in = 1'b1; cyc();
        chk("rst_rise_led", {12'h0, led_b}, 16'h0);
        chk("rst_rise_cnt", step_count_b, 16'h0);
        chk("rst_rise_wrap", {15'h0, wrap_b}, 16'h0);
        chk("rst_rise_cnt_a", step_count_a, 16'h0);
        rst = 1'b0; tick_in = 1'b0; cyc();
        chk("post_rst_seed", {12'h0, led_b}, 16'h1);
        chk("post_rst_cnt", step_count_b, 16'h0);

        // step_count rollover from FFFF
        do_reset();
        preload_b = 1'b1;
        force dut_b.step_count = 16'hFFFF;
        cyc();
        preload_b = 1'b0;
        release dut_b.step_count;
        chk("preload_cnt", step_count_b, 16'hFFFF);
        en = 1'b1; mode = 2'd1; cyc();
        wrap_seen_b = 0;
        tick_in = 1'b1; cyc();
        chk("rollover_cnt", step_count_b, 16'h0);
        chk("rollover_led", {12'h0, led_b}, 16'h2);
        tick_in = 1'b0; cyc();
        chk("rollover_no_wrap", 16'(wrap_seen_b), 16'h0);

        // Randomized traffic against the model
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            tick_in = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
